// File: rtl/adding_machine_sequencer.sv
// Sequencer for the ROM -> pipe -> add -> accumulator adding machine.
// Optional sticky overflow tracking: define OVERFLOW_DETECT_EN.
module adding_machine_sequencer #(
  parameter int IDX_W  = 30,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  base,
  input  logic [CNT_W-1:0]  count,
  input  logic              stall,
  input  logic [DATA_W-1:0] acc_in,
  input  logic              alu_ovf,
  output logic [IDX_W-1:0]  rom_index,
  output logic              pipe_en,
  output logic              acc_en,
  output logic              acc_clr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              overflow
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, FETCH, DRAIN, DONE
  } state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  base_q, idx_q;
  logic [CNT_W-1:0]  cnt_q, rem_q;
  logic              pipe_valid;
  logic [DATA_W-1:0] res_q, res_cur;
  logic              zero_job;

  assign rom_index = idx_q;
  assign zero_job  = (cnt_q == '0);

  // The accumulator is not cleared for an empty job, so mask it.
  assign res_cur = zero_job ? '0 : acc_in;
  assign result  = (state == DONE) ? res_cur : res_q;

  always_comb begin
    state_nx = state;
    pipe_en  = 1'b0;
    acc_en   = 1'b0;
    acc_clr  = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          state_nx = (count == '0) ? DONE : CLEAR;
      end
      CLEAR: begin
        acc_clr  = 1'b1;
        state_nx = FETCH;
      end
      FETCH: begin
        if (!stall) begin
          pipe_en = 1'b1;
          acc_en  = pipe_valid;
          if (rem_q == CNT_W'(1))
            state_nx = DRAIN;
        end
      end
      DRAIN: begin
        acc_en = pipe_valid & ~stall;
        if (!stall)
          state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      idx_q      <= '0;
      rem_q      <= '0;
      pipe_valid <= 1'b0;
      res_q      <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q <= base;
            cnt_q  <= count;
          end
        end
        CLEAR: begin
          idx_q      <= base_q;
          rem_q      <= cnt_q;
          pipe_valid <= 1'b0;
        end
        FETCH: begin
          if (!stall) begin
            pipe_valid <= 1'b1;
            idx_q      <= idx_q + IDX_W'(1);
            rem_q      <= rem_q - CNT_W'(1);
          end
        end
        DONE: res_q <= res_cur;
        default: ;
      endcase
    end
  end

`ifdef OVERFLOW_DETECT_EN
  logic flag_q, ovf_q, ovf_cur;

  assign ovf_cur  = flag_q & ~zero_job;
  assign overflow = (state == DONE) ? ovf_cur : ovf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (state == CLEAR)
        flag_q <= 1'b0;
      else if (acc_en && alu_ovf)
        flag_q <= 1'b1;
      if (state == DONE)
        ovf_q <= ovf_cur;
    end
  end
`else
  logic unused_ovf;

  assign unused_ovf = alu_ovf;
  assign overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_adding_machine_sequencer.sv
// Bench for adding_machine_sequencer with a ROM/pipe/accumulator
// datapath model and a result scoreboard.
module tb_adding_machine_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [29:0] base;
  logic [15:0] count;
  logic        stall;
  logic [31:0] acc_in;
  logic        alu_ovf;
  logic [29:0] rom_index;
  logic        pipe_en, acc_en, acc_clr;
  logic        busy, done;
  logic [31:0] result;
  logic        overflow;

  adding_machine_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .base(base), .count(count), .stall(stall),
    .acc_in(acc_in), .alu_ovf(alu_ovf),
    .rom_index(rom_index), .pipe_en(pipe_en),
    .acc_en(acc_en), .acc_clr(acc_clr),
    .busy(busy), .done(done),
    .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // datapath: ROM (16 words, low index bits), pipe, accumulator
  logic [31:0] rom [16];
  logic [31:0] pipe_q, acc_q, sum;

  assign sum     = acc_q + pipe_q;
  assign acc_in  = acc_q;
  assign alu_ovf = (acc_q[31] == pipe_q[31]) &&
                   (sum[31] != acc_q[31]);

  always @(posedge clk) begin
    if (acc_clr) begin
      pipe_q <= '0;
      acc_q  <= '0;
    end else begin
      if (pipe_en) pipe_q <= rom[rom_index[3:0]];
      if (acc_en)  acc_q  <= sum;
    end
  end

  logic [29:0] issued [$];
  int          viol = 0;

  always @(negedge clk) begin
    if (pipe_en) issued.push_back(rom_index);
    if (acc_en && stall) viol++;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [29:0] base;
    logic [15:0] count;
    logic [31:0] stall;
    logic [31:0] smask;
    int          lat;
    logic [31:0] exp;
    logic        ovf;
  } vec_t;

  logic [31:0] q_res [$];
  logic        q_ovf [$];

  task automatic run_job(input vec_t v);
    int          k;
    bit          got;
    logic [29:0] e;
    logic [31:0] er;
    logic        eo;
    q_res.push_back(v.exp);
    q_ovf.push_back(v.ovf);
    issued.delete();
    start = 1'b1;
    base  = v.base;
    count = v.count;
    stall = 1'b0;
    @(posedge clk); #1;
    k   = 0;
    got = 1'b0;
    while (!got && k < 64) begin
      if (done) got = 1'b1;
      else begin
        start = (k < 32) ? v.smask[k] : 1'b0;
        stall = (k < 32) ? v.stall[k] : 1'b0;
        @(posedge clk); #1;
        k++;
      end
    end
    start = 1'b0;
    stall = 1'b0;
    er = q_res.pop_front();
    eo = q_ovf.pop_front();
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL done_timeout base=%0h cnt=%0d",
               v.base, v.count);
    end else begin
      chk("latency", 64'(k), 64'(v.lat));
      chk("result", 64'(result), 64'(er));
      chk("overflow", 64'(overflow), 64'(eo));
      chk("busy_in_done", 64'(busy), 64'd1);
      chk("idx_count", 64'(issued.size()),
          64'(v.count));
      for (int i = 0; i < int'(v.count) &&
           i < issued.size(); i++) begin
        e = v.base + 30'(i);
        chk("idx", 64'(issued[i]), 64'(e));
      end
    end
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("result_hold", 64'(result), 64'(er));
  endtask

`ifdef OVERFLOW_DETECT_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  vec_t vt [6];
  vec_t hv;
  int   dn;

  initial begin
    // count=4 with start pulses while busy
    vt[0] = '{30'd0, 16'd4, 32'h0,
              32'h2A, 6, 32'd10, 1'b0};
    // empty job right after a non-empty one
    vt[1] = '{30'd0, 16'd0, 32'h0,
              32'h0, 0, 32'd0, 1'b0};
    // three FETCH stalls and one DRAIN stall
    vt[2] = '{30'd0, 16'd4, 32'h10E,
              32'h0, 10, 32'd10, 1'b0};
    // index wrap 3FFFFFFE..1
    vt[3] = '{30'h3FFFFFFE, 16'd4, 32'h0,
              32'h0, 6, 32'd34, 1'b0};
    vt[4] = '{30'd5, 16'd1, 32'h0,
              32'h0, 3, 32'd6, 1'b0};
    vt[5] = '{30'd10, 16'd3, 32'h24,
              32'h0, 7, 32'd36, 1'b0};

    for (int i = 0; i < 16; i++) rom[i] = 32'(i + 1);
    reset = 1'b0;
    start = 1'b0;
    base  = '0;
    count = '0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_index", 64'(rom_index), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_en", 64'({pipe_en, acc_en, acc_clr}),
        64'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) run_job(vt[i]);

    // reset mid-FETCH aborts the job silently
    start = 1'b1;
    base  = 30'd0;
    count = 16'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_index", 64'(rom_index), 64'd0);
    chk("mid_rst_result", 64'(result), 64'd0);
    dn = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("mid_rst_busy2", 64'(busy), 64'd0);
    reset = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) dn++;
    end
    chk("no_done_after_rst", 64'(dn), 64'd0);
    chk("result_after_rst", 64'(result), 64'd0);

    // signed overflow on 7FFFFFFF + 1, then clean job
    rom[0] = 32'h7FFFFFFF;
    rom[1] = 32'h1;
    hv = '{30'd0, 16'd2, 32'h0, 32'h0,
           4, 32'h80000000, OVF_ON};
    run_job(hv);
    rom[0] = 32'h1;
    hv = '{30'd0, 16'd2, 32'h0, 32'h0,
           4, 32'd2, 1'b0};
    run_job(hv);

    chk("acc_en_vs_stall", 64'(viol), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
